// File: rtl/mdu_result_fifo_pkg.sv
// rtl/mdu_result_fifo_pkg.sv - shared result types for MDU, result FIFO and CDB arbiter
package mdu_result_fifo_pkg;

    localparam int XLEN       = 32;
    localparam int ROB_ID_LEN = 5;

    typedef logic [XLEN-1:0]       word_t;
    typedef logic [ROB_ID_LEN-1:0] rob_id_t;

    typedef struct packed {
        word_t   data;
        rob_id_t reg_id;
    } mdu_res_t;

    function automatic mdu_res_t make_res(input word_t data, input rob_id_t reg_id);
        mdu_res_t r;
        r.data   = data;
        r.reg_id = reg_id;
        return r;
    endfunction

endpackage

// File: rtl/mdu_result_fifo_ram.sv
// rtl/mdu_result_fifo_ram.sv - result storage, one write port, one asynchronous read port
module fifo_ram
    import mdu_result_fifo_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int PTR_LEN = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               we,
    input  logic [PTR_LEN-1:0] waddr,
    input  mdu_res_t           wdata,
    input  logic [PTR_LEN-1:0] raddr,
    output mdu_res_t           rdata
);

    // Storage is deliberately not reset; the control logic never exposes stale entries.
    mdu_res_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mdu_result_fifo.sv
// rtl/mdu_result_fifo.sv - in-order result buffer between the MDU and the CDB arbiter
module mdu_result_fifo
    import mdu_result_fifo_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int PTR_LEN = $clog2(DEPTH),
    parameter int CNT_LEN = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid_i,
    input  word_t              in_data_i,
    input  rob_id_t            in_reg_id_i,
    output logic               ready_o,
    output logic               cdb_valid_o,
    output word_t              cdb_data_o,
    output rob_id_t            cdb_reg_id_o,
    input  logic               cdb_ready_i,
    output logic [CNT_LEN-1:0] count_o
);

    logic [PTR_LEN-1:0] wr_ptr_q;
    logic [PTR_LEN-1:0] rd_ptr_q;
    logic [CNT_LEN-1:0] cnt_q;
    logic               push;
    logic               pop;
    mdu_res_t           head;

    // Both handshake flags come from registered state only, so CDB grant never
    // reaches back into MDU issue combinationally.
    assign ready_o     = (cnt_q != CNT_LEN'(DEPTH));
    assign cdb_valid_o = (cnt_q != '0);
    assign count_o     = cnt_q;

    assign push = in_valid_i && ready_o;
    assign pop  = cdb_valid_o && cdb_ready_i;

    fifo_ram #(
        .DEPTH   (DEPTH),
        .PTR_LEN (PTR_LEN)
    ) u_ram (
        .clk   (clk),
        .we    (push && !flush),
        .waddr (wr_ptr_q),
        .wdata (make_res(in_data_i, in_reg_id_i)),
        .raddr (rd_ptr_q),
        .rdata (head)
    );

    assign cdb_data_o   = cdb_valid_o ? head.data   : '0;
    assign cdb_reg_id_o = cdb_valid_o ? head.reg_id : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_LEN'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_LEN'(1);
            end
            cnt_q <= cnt_q + CNT_LEN'(push) - CNT_LEN'(pop);
        end
    end

`ifndef SYNTHESIS
    a_push_ready : assert property (@(posedge clk) disable iff (!rst_n) push |-> ready_o);
    a_cnt_max    : assert property (@(posedge clk) disable iff (!rst_n) cnt_q <= CNT_LEN'(DEPTH));
    a_valid_rise : assert property (@(posedge clk) disable iff (!rst_n)
                                    $rose(cdb_valid_o) |-> $past(push));
`endif

endmodule

// File: tb/tb_mdu_result_fifo.sv
// tb/tb_mdu_result_fifo.sv - directed bench with scoreboard monitor for mdu_result_fifo
module tb_mdu_result_fifo;
    import mdu_result_fifo_pkg::*;

    localparam int DEPTH   = 4;
    localparam int CNT_LEN = $clog2(DEPTH + 1);

    logic               clk = 1'b0;
    logic               rst_n;
    logic               flush;
    logic               in_valid;
    word_t              in_data;
    rob_id_t            in_reg_id;
    logic               ready;
    logic               cdb_valid;
    word_t              cdb_data;
    rob_id_t            cdb_reg_id;
    logic               cdb_ready;
    logic [CNT_LEN-1:0] count;

    int checks = 0;
    int errors = 0;
    mdu_res_t sb[$];

    mdu_result_fifo #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid_i   (in_valid),
        .in_data_i    (in_data),
        .in_reg_id_i  (in_reg_id),
        .ready_o      (ready),
        .cdb_valid_o  (cdb_valid),
        .cdb_data_o   (cdb_data),
        .cdb_reg_id_o (cdb_reg_id),
        .cdb_ready_i  (cdb_ready),
        .count_o      (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Drive one push that the bench expects to be accepted.
    task automatic issue(input word_t d, input rob_id_t id);
        in_valid  = 1'b1;
        in_data   = d;
        in_reg_id = id;
        sb.push_back(make_res(d, id));
    endtask

    // Monitor: every CDB handshake pops the oldest expected result.
    always @(negedge clk) begin
        if (rst_n && !flush && cdb_valid && cdb_ready) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'(cdb_reg_id), 32'hFFFF_FFFF);
            end else begin
                mdu_res_t e;
                e = sb.pop_front();
                check("pop_data", cdb_data, e.data);
                check("pop_id", 32'(cdb_reg_id), 32'(e.reg_id));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: timeout reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h99;
        in_reg_id = 5'd7;
        cdb_ready = 1'b0;

        #3;
        check("rst_ready", 32'(ready), 1);
        check("rst_valid", 32'(cdb_valid), 0);
        check("rst_count", 32'(count), 0);
        check("rst_data", cdb_data, 0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_count", 32'(count), 0);
        check("rst_hold_valid", 32'(cdb_valid), 0);

        in_valid = 1'b0;
        rst_n    = 1'b1;
        cyc();

        // First push after reset is visible the cycle after.
        issue(32'h0000_0011, 5'd3);
        check("no_bypass", 32'(cdb_valid), 0);
        cyc();
        in_valid = 1'b0;
        check("first_valid", 32'(cdb_valid), 1);
        check("first_data", cdb_data, 32'h11);
        check("first_id", 32'(cdb_reg_id), 3);
        cdb_ready = 1'b1;
        cyc();
        cdb_ready = 1'b0;
        check("first_drained", 32'(count), 0);

        // Fill to DEPTH under CDB back-pressure.
        for (int i = 1; i <= 4; i++) begin
            issue(32'h100 + 32'(i), rob_id_t'(i));
            cyc();
        end
        check("full_count", 32'(count), 4);
        check("full_ready", 32'(ready), 0);
        in_valid  = 1'b1;
        in_data   = 32'h105;
        in_reg_id = 5'd5;
        cyc();
        in_valid = 1'b0;
        check("full_ignore_count", 32'(count), 4);
        check("full_head", 32'(cdb_reg_id), 1);

        // One pop from full: ready stays low that cycle.
        cdb_ready = 1'b1;
        #1;
        check("pop_cycle_ready", 32'(ready), 0);
        cyc();
        cdb_ready = 1'b0;
        check("after_pop_ready", 32'(ready), 1);
        check("after_pop_count", 32'(count), 3);
        check("after_pop_head", 32'(cdb_reg_id), 2);
        check("after_pop_data", cdb_data, 32'h102);

        cdb_ready = 1'b1;
        repeat (3) cyc();
        cdb_ready = 1'b0;
        check("drain_count", 32'(count), 0);

        // Steady stream, wrapping pointers several times.
        cdb_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            issue(32'h200 + 32'(i), rob_id_t'(10 + i));
            cyc();
            check("stream_count", 32'(count), 1);
        end
        in_valid = 1'b0;
        cyc();
        cdb_ready = 1'b0;
        check("stream_end_count", 32'(count), 0);

        // Flush with simultaneous push and pop at count 3.
        for (int i = 0; i < 3; i++) begin
            issue(32'h300 + 32'(i), rob_id_t'(20 + i));
            cyc();
        end
        in_valid = 1'b0;
        check("pre_flush_count", 32'(count), 3);
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h333;
        in_reg_id = 5'd23;
        cdb_ready = 1'b1;
        sb.delete();
        cyc();
        flush     = 1'b0;
        in_valid  = 1'b0;
        cdb_ready = 1'b0;
        check("flush_count", 32'(count), 0);
        check("flush_valid", 32'(cdb_valid), 0);
        check("flush_ready", 32'(ready), 1);
        check("flush_data", cdb_data, 0);
        issue(32'h444, 5'd24);
        cyc();
        in_valid = 1'b0;
        check("post_flush_count", 32'(count), 1);
        check("post_flush_head", 32'(cdb_reg_id), 24);
        cdb_ready = 1'b1;
        cyc();
        cdb_ready = 1'b0;

        // Asynchronous reset between edges.
        issue(32'h555, 5'd25);
        cyc();
        issue(32'h556, 5'd26);
        cyc();
        in_valid = 1'b0;
        check("pre_reset_count", 32'(count), 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_valid", 32'(cdb_valid), 0);
        check("async_count", 32'(count), 0);
        check("async_ready", 32'(ready), 1);
        check("async_id", 32'(cdb_reg_id), 0);
        sb.delete();
        cyc();
        rst_n = 1'b1;
        cyc();
        check("post_reset_count", 32'(count), 0);

        check("sb_leftover", 32'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
